unified_mem_arbiter: RTL
========================

Name: unified_mem_arbiter

Overview:
- Shares one single-port unified memory between the fetch stage (instruction port, I) and the memory stage (data port, D) of the 5-stage core.
- Arbitrates between the two ports, sequences each memory transaction through a req/ack handshake and returns read data to the winning port.
- Data wins by default; a starvation counter guarantees forward progress of fetch.
- A fetch flush input (driven by the core's branch-taken signal) discards an in-flight fetch result.

Parameters:
STARVE_LIMIT, 4, consecutive D grants allowed while if_req is pending before I is forced to win (legal range 1..15)
AW, 32, address width
DW, 32, data width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
if_req  in  1  fetch transaction request (read only)
if_addr  in  AW  fetch address
if_flush  in  1  discard in-flight fetch result
if_gnt  out  1  one-cycle pulse: fetch request accepted
if_rvalid  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  DW  fetched word
d_req  in  1  data transaction request
d_we  in  1  1 = store, 0 = load
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_size  in  3  funct3 width code, passed through unchanged
d_gnt  out  1  one-cycle pulse: data request accepted
d_rvalid  out  1  one-cycle pulse: completion; d_rdata valid for loads
d_rdata  out  DW  load data
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  write enable
mem_addr  out  AW  address
mem_wdata  out  DW  write data
mem_size  out  3  width code
mem_ack  in  1  one-cycle completion; mem_rdata valid same cycle
mem_rdata  in  DW  read data

Behaviour:
- Reset:
  - State goes to IDLE; the starvation counter, drop flag and all outputs go to 0, including rdata and mem_* buses.
  - Reset mid-transaction abandons it: no rvalid is produced and mem_req is low the cycle after reset.
- States: IDLE, BUSY_I, BUSY_D. All outputs are registered.
- IDLE, sampling requests in cycle T:
  - No request: stay IDLE.
  - Only one port requesting: that port wins.
  - Both requesting: D wins, unless the starvation counter equals STARVE_LIMIT, in which case I wins.
  - Winner: at T+1, enter BUSY_x, gnt_x = 1 for one cycle, mem_req = 1, and the mem_* fields are latched from the winning port.
  - I requests: mem_we = 0 and mem_size = 3'b010.
- Starvation counter:
  - Increments on a D grant while if_req is high, saturating at STARVE_LIMIT.
  - Clears on any I grant.
  - Unchanged on a D grant with if_req low.
- BUSY_x:
  - mem_* is held stable until mem_ack.
  - On mem_ack in cycle A: at A+1, mem_req = 0, state = IDLE, x_rvalid = 1 for one cycle, and x_rdata latches mem_rdata. For D stores, d_rdata is unchanged.
  - New requests may be sampled in the A+1 cycle, giving a new grant at A+2.
  - Minimum turnaround with a zero-wait memory (ack at T+1) is 2 cycles per transaction.
- Requester rules:
  - req, addr and data must be held from assertion until gnt.
  - req must be low in the cycle after gnt unless a new transaction is intended.
  - Any req high in an IDLE cycle is a new request.
  - Ports not granted keep waiting; their requests are never dropped.
- Flush:
  - if_flush high in any BUSY_I cycle, including the mem_ack cycle, sets the drop flag.
  - At completion with the drop flag set, if_rvalid stays 0 and if_rdata is not updated; the flag then clears.
  - The memory transaction itself is never aborted.
  - if_flush in IDLE or BUSY_D has no effect.
- The gnt and rvalid outputs of the two ports are never high in the same cycle.
- mem_ack while mem_req is low is ignored.

Test Plan:
- Single fetch:
  - Stimulus: if_req = 1, if_addr = 0x40 at T; mem_ack at T+2 with mem_rdata = 0x00000013.
  - Required: if_gnt at T+1; mem_req high over T+1..T+2 with mem_addr = 0x40 and mem_we = 0; if_rvalid = 1 with if_rdata = 0x13 at T+3.
- Store then load:
  - Stimulus: store of 0xDEADBEEF to 0x100 (d_size = 3'b010), then a load from 0x100 with the memory model returning the stored value.
  - Required: mem_we = 1 on the store; d_rvalid on both; d_rdata = 0xDEADBEEF after the load; d_rdata unchanged after the store.
- Contention with STARVE_LIMIT = 4:
  - Stimulus: if_req and d_req both held continuously, zero-wait memory.
  - Required grant order: D, D, D, D, I, D, D, D, D, I; the counter clears after each I grant.
- Flush:
  - Stimulus: fetch granted; if_flush pulsed while BUSY_I; ack with 0x12345678.
  - Required: no if_rvalid; if_rdata keeps its old value; the next fetch returns data normally.
- Reset mid-transaction:
  - Stimulus: rst asserted during BUSY_D.
  - Required: next cycle, state IDLE, mem_req = 0, no d_rvalid; all outputs 0 and counter 0.
- Back-to-back:
  - Stimulus: d_req re-raised in the d_rvalid cycle, zero-wait memory.
  - Required: new d_gnt exactly one cycle after d_rvalid.

Source files
------------

// File: rtl/unified_mem_arbiter_if.sv
// Handshake bundle between the fetch/data requesters, the arbiter and the
// shared single-port memory. The arbiter uses the slave view.
interface unified_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Fetch port
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  // Data port
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [2:0]    d_size;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  // Memory side
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    mem_size;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, if_flush,
    input  d_req, d_we, d_addr, d_wdata, d_size,
    input  mem_ack, mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_size
  );

  modport master (
    output if_req, if_addr, if_flush,
    output d_req, d_we, d_addr, d_wdata, d_size,
    output mem_ack, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_size
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Fetch/data arbiter in front of one single-port memory: data wins by default,
// a starvation counter forces a fetch grant, and flush discards fetch results.
module unified_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 32,
  parameter int DW           = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  unified_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  localparam logic [3:0] LIMIT   = 4'(STARVE_LIMIT);
  localparam logic [2:0] SIZE_IF = 3'b010;

  state_e        state_q;
  logic [3:0]    starve_q;
  logic          drop_q;
  logic          if_gnt_q, if_rvalid_q;
  logic [DW-1:0] if_rdata_q;
  logic          d_gnt_q, d_rvalid_q;
  logic [DW-1:0] d_rdata_q;
  logic          mem_req_q, mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [2:0]    mem_size_q;

  logic starved, d_win, i_win;

  // Fetch only beats a pending data request once it has been passed over
  // STARVE_LIMIT times in a row.
  always_comb begin
    starved = (starve_q == LIMIT);
    d_win   = bus.d_req && !(bus.if_req && starved);
    i_win   = bus.if_req && !d_win;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      drop_q      <= 1'b0;
      if_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      d_gnt_q     <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_size_q  <= '0;
    end else begin
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (d_win) begin
            state_q     <= BUSY_D;
            d_gnt_q     <= 1'b1;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.d_we;
            mem_addr_q  <= bus.d_addr;
            mem_wdata_q <= bus.d_wdata;
            mem_size_q  <= bus.d_size;
            if (bus.if_req && (starve_q < LIMIT))
              starve_q <= starve_q + 4'd1;
          end else if (i_win) begin
            state_q     <= BUSY_I;
            if_gnt_q    <= 1'b1;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.if_addr;
            mem_wdata_q <= '0;
            mem_size_q  <= SIZE_IF;
            starve_q    <= '0;
            drop_q      <= 1'b0;
          end
        end
        BUSY_I: begin
          if (bus.mem_ack) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            drop_q    <= 1'b0;
            // A flush in the ack cycle itself still discards the result.
            if (!(drop_q || bus.if_flush)) begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= bus.mem_rdata;
            end
          end else if (bus.if_flush) begin
            drop_q <= 1'b1;
          end
        end
        BUSY_D: begin
          if (bus.mem_ack) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            d_rvalid_q <= 1'b1;
            if (!mem_we_q)
              d_rdata_q <= bus.mem_rdata;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.if_gnt    = if_gnt_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_size  = mem_size_q;

endmodule
